// File: rtl/icache_dm_refill.sv
// Direct-mapped, read-only instruction cache with a four-state miss-refill FSM and fence.i flush.
// Optional hit/miss counters are compiled in when ICACHE_PERF_CNT_EN is defined.
module icache_dm_refill #(
    parameter int ADDR_W    = 32,
    parameter int SET_BITS  = 6,
    parameter int WORD_BITS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:2] addr,
    output logic              ready,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:2] mem_addr,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - SET_BITS - WORD_BITS - 2;
    localparam int SETS  = 1 << SET_BITS;
    localparam int WORDS = 1 << (SET_BITS + WORD_BITS);
    localparam logic [WORD_BITS-1:0] LAST_BEAT = '1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_RESP} state_t;

    state_t               r_state, w_next;
    logic [SET_BITS-1:0]  r_idx;
    logic [TAG_W-1:0]     r_tag;
    logic [WORD_BITS-1:0] r_off;
    logic [WORD_BITS-1:0] r_beat;
    logic [SETS-1:0]      r_valid;
    logic                 r_flush_pend;
    logic                 r_lk_valid;
    logic [TAG_W-1:0]     r_lk_tag;
    logic [31:0]          r_lk_word;
    logic [31:0]          r_cap;
    logic [31:0]          r_rd_data;

    logic [TAG_W-1:0]     r_tag_mem  [SETS];
    logic [31:0]          r_data_mem [WORDS];

    logic [WORD_BITS-1:0] w_in_off;
    logic [SET_BITS-1:0]  w_in_idx;
    logic [TAG_W-1:0]     w_in_tag;
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_beat;
    logic                 w_last_beat;
    logic                 w_accept;

    assign w_in_off    = addr[WORD_BITS+1:2];
    assign w_in_idx    = addr[SET_BITS+WORD_BITS+1:WORD_BITS+2];
    assign w_in_tag    = addr[ADDR_W-1:SET_BITS+WORD_BITS+2];
    assign w_hit       = (r_state == S_LOOKUP) && r_lk_valid && (r_lk_tag == r_tag);
    assign w_miss      = (r_state == S_LOOKUP) && !w_hit;
    assign w_beat      = (r_state == S_REFILL) && mem_rvalid;
    assign w_last_beat = w_beat && (r_beat == LAST_BEAT);
    assign w_accept    = ready && rd_req;
    assign mem_addr    = {r_tag, r_idx, {WORD_BITS{1'b0}}};

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every output and w_next gets a default first so no path leaves a latch behind.
    always_comb begin
        w_next   = r_state;
        ready    = 1'b0;
        rd_valid = 1'b0;
        rd_data  = r_rd_data;
        mem_req  = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (rd_req) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    // Accepting the next fetch here keeps back-to-back hits at one per cycle.
                    ready    = 1'b1;
                    rd_valid = 1'b1;
                    rd_data  = r_lk_word;
                    w_next   = rd_req ? S_LOOKUP : S_IDLE;
                end else begin
                    mem_req = 1'b1;
                    w_next  = S_REFILL;
                end
            end
            S_REFILL: begin
                if (w_last_beat) w_next = S_RESP;
            end
            S_RESP: begin
                rd_valid = 1'b1;
                rd_data  = r_cap;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_tag        <= '0;
            r_off        <= '0;
            r_beat       <= '0;
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
            r_lk_valid   <= 1'b0;
            r_cap        <= '0;
            r_rd_data    <= '0;
        end else begin
            if (w_accept) begin
                r_idx      <= w_in_idx;
                r_tag      <= w_in_tag;
                r_off      <= w_in_off;
                r_lk_valid <= r_valid[w_in_idx] & ~flush;
            end
            if (rd_valid) r_rd_data <= rd_data;
            if (w_beat) begin
                r_beat <= r_beat + 1'b1;
                if (r_beat == r_off) r_cap <= mem_rdata;
            end
            if (w_last_beat) r_valid[r_idx] <= 1'b1;
            if (flush && (r_state == S_IDLE || w_hit)) r_valid <= '0;
            // A deferred flush lands after the response, so it also drops the line just filled.
            if (r_state == S_RESP && (flush || r_flush_pend)) begin
                r_valid      <= '0;
                r_flush_pend <= 1'b0;
            end else if (flush && (r_state == S_REFILL || w_miss)) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    // NOTE: tag/data arrays carry no reset; the valid vector alone decides whether contents count.
    always_ff @(posedge clk) begin
        if (w_beat)      r_data_mem[{r_idx, r_beat}] <= mem_rdata;
        if (w_last_beat) r_tag_mem[r_idx] <= r_tag;
        if (w_accept) begin
            r_lk_tag  <= r_tag_mem[w_in_idx];
            r_lk_word <= r_data_mem[{w_in_idx, w_in_off}];
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit)  r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: doc/icache_dm_refill.md
Name: icache_dm_refill

Overview:
- Parametrised, direct-mapped, read-only instruction cache for the RV32I core fetch stage.
- Successor to the flat preloaded instruction RAM: tag/valid arrays, a miss-refill state machine to a backing memory, and a flush (fence.i) input.
- Hit latency is 1 cycle, synchronous read, the same as the current fetch path.
- The core stalls on `ready` low.

Parameters:
- ADDR_W, 32, byte-address width; address ports carry bits [ADDR_W-1:2].
- SET_BITS, 6, log2 of the set count (64 lines).
- WORD_BITS, 2, log2 of words per line (4 words = 16 B).
- TAG_W, ADDR_W-SET_BITS-WORD_BITS-2, derived localparam, not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- rd_req  in  1  fetch request, sampled only when ready=1
- addr  in  ADDR_W-2 [ADDR_W-1:2]  word address of fetch
- ready  out  1  cache can accept rd_req this cycle
- rd_valid  out  1  rd_data valid this cycle (one-cycle pulse per request)
- rd_data  out  32  fetched instruction
- flush  in  1  invalidate all lines (one-cycle pulse)
- mem_req  out  1  refill request pulse
- mem_addr  out  ADDR_W-2 [ADDR_W-1:2]  line-aligned word address (low WORD_BITS zero)
- mem_rvalid  in  1  refill beat valid
- mem_rdata  in  32  refill beat data, words delivered in ascending offset order

Behaviour:
- Reset (rst_n=0 at posedge):
  - All valid bits are cleared and state goes to IDLE.
  - ready=1 after reset; rd_valid=0, rd_data=0, mem_req=0, mem_addr=0.
  - The pending-flush flag and the beat counter are cleared.
  - A reset during REFILL abandons the refill; later mem_rvalid beats are ignored.
- Address split: offset=addr[WORD_BITS+1:2], index=addr[SET_BITS+WORD_BITS+1:WORD_BITS+2], tag=upper TAG_W bits.
- IDLE (ready=1), on rd_req:
  - The request is registered (index, tag, offset) and the tag/valid/data arrays are read synchronously.
  - The next cycle goes to LOOKUP.
- LOOKUP (ready=0):
  - Hit = valid[index] and tag match. On a hit: rd_valid=1, rd_data=word, and the same cycle returns to IDLE.
  - Net hit latency: request at cycle N produces data at N+1.
  - ready is combinationally 1 in a hit LOOKUP cycle, so back-to-back hits sustain 1 fetch per cycle.
  - On a miss: mem_req=1 for exactly one cycle with mem_addr={tag,index,0}; go to REFILL.
- REFILL (ready=0):
  - Each mem_rvalid beat writes data[index][beat_cnt]; beat_cnt increments from 0 and wraps at 2^WORD_BITS.
  - The beat whose count equals the requested offset is also captured into rd_data.
  - On the last beat: tag[index]=tag, valid[index]=1, go to RESP.
  - Beats may arrive with arbitrary gaps; zero gaps are legal.
- RESP (ready=0): rd_valid=1 with the captured word for one cycle, then IDLE.
- rd_data holds its last value when rd_valid=0.
- Flush:
  - In IDLE, all valid bits are cleared at the next edge, and any rd_req in that same cycle is treated as a miss.
  - In LOOKUP on a hit, the flush takes effect at the next edge, same as in IDLE.
  - In REFILL or RESP, the flush sets a pending flag. The flag is applied on return to IDLE, after the RESP word is delivered, which also invalidates the refilled line.
  - Flush is idempotent: multiple pulses while pending collapse into one.
- rd_req while ready=0 is ignored; the core holds addr and rd_req until accepted.
- mem_rvalid outside REFILL is ignored.
- Arrays: data is (2^SET_BITS)*(2^WORD_BITS) x 32 with one synchronous write port and one read port; tag is 2^SET_BITS x TAG_W; valid is a 2^SET_BITS flop vector.

Optional Feature:
- ICACHE_PERF_CNT_EN defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments on each LOOKUP hit; miss_cnt increments on each LOOKUP miss.
  - Both wrap at 2^32, reset to 0, and are unaffected by flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold miss: reset, then rd_req addr=0x100>>2 (index 16, tag 0). Required response:
  - mem_req pulse with mem_addr=0x40.
  - Feed beats 0x11,0x22,0x33,0x44; rd_valid with rd_data=0x11 one cycle after the last beat.
- Hit after fill: then addr=0x10C>>2 → rd_valid at N+1 with rd_data=0x44, no mem_req. Back-to-back hits on 0x100..0x10C deliver 4 words in 4 consecutive cycles.
- Conflict eviction: addr=0x500>>2 (index 16, tag 1) → miss, mem_addr=0x140; refill with 0xA0..0xA3. A subsequent 0x104 misses again.
- Offset capture with gaps: request 0x208>>2, beats with 3-cycle gaps → rd_data=beat 2 and rd_valid only after beat 3.
- Flush during refill: flush pulse mid-REFILL of 0x300 → RESP still delivers the word; the next request to 0x300 misses (mem_req reasserted).
- Reset mid-refill: rst_n=0 after beat 1, then stray mem_rvalid beats → ready=1, no rd_valid. Next 0x100 misses.
- With ICACHE_PERF_CNT_EN defined: 1 miss + 3 hits → miss_cnt=1, hit_cnt=3.
